// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared types and JEDEC command constants for the flash program path
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_POLL,
        ST_GAP,
        ST_DONE
    } prog_state_t;

    localparam logic [15:0] CMD_ADDR1 = 16'h5555;
    localparam logic [15:0] CMD_ADDR2 = 16'h2AAA;
    localparam logic [15:0] CMD_D1    = 16'h00AA;
    localparam logic [15:0] CMD_D2    = 16'h0055;
    localparam logic [15:0] CMD_PROG  = 16'h00A0;

    localparam int DQ7 = 7;

    // Index of the final (data) bus cycle of the program sequence
    localparam logic [1:0] LAST_CMD = 2'd3;

    function automatic logic [15:0] cmd_addr(input logic [1:0] idx, input logic [15:0] addr);
        logic [15:0] r;
        case (idx)
            2'd0:    r = CMD_ADDR1;
            2'd1:    r = CMD_ADDR2;
            2'd2:    r = CMD_ADDR1;
            default: r = addr;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] cmd_data(input logic [1:0] idx, input logic [15:0] data);
        logic [15:0] r;
        case (idx)
            2'd0:    r = CMD_D1;
            2'd1:    r = CMD_D2;
            2'd2:    r = CMD_PROG;
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter with synchronous clear and programmable rollover
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + 1'b1;
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/flash_prog_ctrl.sv
// rtl/flash_prog_ctrl.sv - JEDEC word-program sequencer with DQ7 completion polling
module flash_prog_ctrl
    import flash_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int WE_CYC    = 4,
    parameter int HOLD_CYC  = 2,
    parameter int READ_CYC  = 6,
    parameter int MAX_POLLS = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [15:0] data_in,
    output logic [15:0] flash_addr,
    output logic [15:0] flash_dout,
    output logic        drive_en,
    output logic        ce,
    output logic        oe,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
    localparam logic [PW-1:0] POLL_LAST  = PW'(MAX_POLLS - 1);
    localparam logic [3:0]    SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0]    WE_LAST    = 4'(WE_CYC - 1);
    localparam logic [3:0]    HOLD_LAST  = 4'(HOLD_CYC - 1);
    localparam logic [3:0]    READ_LAST  = 4'(READ_CYC - 1);

    prog_state_t   state;
    logic [15:0]   lat_addr;
    logic [15:0]   lat_data;
    logic [1:0]    cmd_idx;
    logic [PW-1:0] poll_cnt;

    logic          counting;
    logic [3:0]    phase_last;
    logic [3:0]    tmr_cnt;
    logic          tmr_flag;
    logic          phase_done;
    logic          tmr_clear;

    // Only DQ7 of the read bus carries completion status
    logic unused_data_bits;
    assign unused_data_bits = ^{data_in[15:DQ7+1], data_in[DQ7-1:0], tmr_cnt};

    assign counting = (state == ST_SETUP) || (state == ST_PULSE) ||
                      (state == ST_HOLD)  || (state == ST_POLL);

    always_comb begin
        phase_last = 4'd0;
        case (state)
            ST_SETUP: phase_last = SETUP_LAST;
            ST_PULSE: phase_last = WE_LAST;
            ST_HOLD:  phase_last = HOLD_LAST;
            ST_POLL:  phase_last = READ_LAST;
            default:  phase_last = 4'd0;
        endcase
    end

    // Every exit from a timed state happens on phase_done, so clearing on it
    // (and holding clear in untimed states) restarts the timer on each state change.
    assign phase_done = counting && tmr_flag;
    assign tmr_clear  = !counting || phase_done;

    flex_counter #(
        .NUM_CNT_BITS(4)
    ) u_phase_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (tmr_clear),
        .count_enable (counting),
        .rollover_val (phase_last),
        .count_out    (tmr_cnt),
        .rollover_flag(tmr_flag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            lat_addr   <= '0;
            lat_data   <= '0;
            cmd_idx    <= '0;
            poll_cnt   <= '0;
            flash_addr <= '0;
            flash_dout <= '0;
            drive_en   <= 1'b0;
            ce         <= 1'b1;
            oe         <= 1'b1;
            we         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_addr   <= wr_addr;
                        lat_data   <= wr_data;
                        cmd_idx    <= '0;
                        poll_cnt   <= '0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        ce         <= 1'b0;
                        oe         <= 1'b1;
                        we         <= 1'b1;
                        drive_en   <= 1'b1;
                        flash_addr <= cmd_addr(2'd0, wr_addr);
                        flash_dout <= cmd_data(2'd0, wr_data);
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_done) begin
                        we    <= 1'b0;
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (phase_done) begin
                        we    <= 1'b1;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (phase_done) begin
                        if (cmd_idx != LAST_CMD) begin
                            cmd_idx    <= cmd_idx + 2'd1;
                            flash_addr <= cmd_addr(cmd_idx + 2'd1, lat_addr);
                            flash_dout <= cmd_data(cmd_idx + 2'd1, lat_data);
                            state      <= ST_SETUP;
                        end else begin
                            // Release the bus in the same clock oe asserts
                            drive_en   <= 1'b0;
                            oe         <= 1'b0;
                            flash_addr <= lat_addr;
                            state      <= ST_POLL;
                        end
                    end
                end
                ST_POLL: begin
                    if (phase_done) begin
                        ce <= 1'b1;
                        oe <= 1'b1;
                        if (data_in[DQ7] == lat_data[DQ7]) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else if (poll_cnt == POLL_LAST) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            state    <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    ce    <= 1'b0;
                    oe    <= 1'b0;
                    state <= ST_POLL;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
